// File: rtl/count_sequencer_pkg.sv
// Shared constants for the count sequencer: FSM state codes and default counter width.
package count_sequencer_pkg;

   localparam int DEF_WIDTH = 7;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/count_datapath.sv
// WIDTH-bit count register with a hold / increment / clear next-value mux.
module count_datapath
   import count_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Clear has priority over increment; neither asserted means hold.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc) begin
         q_d = q_q + WIDTH'(1);
      end
   end

   // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/count_sequencer.sv
// Controller sequencing the shared counter through start, pause/resume, terminal count and done/ack.
module count_sequencer
   import count_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [WIDTH-1:0] limit,
   input  logic             ack,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             paused,
   output logic             tc,
   output logic             done,
   output logic [1:0]       state
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             mode_q, mode_d;
   logic             inc, clr;
   logic             at_limit;

   count_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk   (clk),
      .reset (reset),
      .inc   (inc),
      .clr   (clr),
      .q     (q)
   );

   assign at_limit = (q == limit_q);

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      limit_d = limit_q;
      mode_d  = mode_q;
      inc     = 1'b0;
      clr     = 1'b0;
      case (state_q)
         S_IDLE: begin
            clr = 1'b1;
            if (start) begin
               state_d = S_RUN;
               limit_d = limit;
               mode_d  = mode;
            end
         end
         S_RUN: begin
            // stop outranks terminal count, and start is ignored here.
            if (stop) begin
               state_d = S_PAUSE;
            end else if (at_limit) begin
               if (mode_q) begin
                  clr = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               inc = 1'b1;
            end
         end
         S_PAUSE: begin
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (ack) begin
               state_d = S_IDLE;
               clr     = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         limit_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         limit_q <= limit_d;
         mode_q  <= mode_d;
      end
   end

   assign busy   = (state_q == S_RUN) || (state_q == S_PAUSE);
   assign paused = (state_q == S_PAUSE);
   assign tc     = (state_q == S_RUN) && at_limit;
   assign done   = (state_q == S_DONE);
   assign state  = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: vector table, directed corner sequences, randomized model check.
module tb_count_sequencer;

   localparam int W   = 7;
   localparam int MAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset, start, stop, mode, ack;
   logic [W-1:0] limit;
   logic [W-1:0] q;
   logic         busy, paused, tc, done;
   logic [1:0]   state;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural reference: state as a spec code, count as plain integer arithmetic.
   int m_st   = 0;
   int m_q    = 0;
   int m_lim  = 0;
   int m_mode = 0;

   typedef struct {
      logic         rst, st, sp, md;
      logic [W-1:0] lim;
      logic         ak;
      logic [W-1:0] eq;
      logic [1:0]   est;
      logic         etc, edone;
   } vec_t;

   vec_t vecs[13];

   count_sequencer #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .stop   (stop),
      .mode   (mode),
      .limit  (limit),
      .ack    (ack),
      .q      (q),
      .busy   (busy),
      .paused (paused),
      .tc     (tc),
      .done   (done),
      .state  (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_step(input bit rs, input bit st, input bit sp,
                                      input bit md, input int lm, input bit ak);
      if (rs) begin
         m_st = 0; m_q = 0; m_lim = 0; m_mode = 0;
         return;
      end
      case (m_st)
         0: if (st) begin m_st = 1; m_lim = lm; m_mode = md; m_q = 0; end
         1: begin
            if (sp) m_st = 2;
            else if (m_q == m_lim) begin
               if (m_mode == 0) m_st = 3;
               else m_q = 0;
            end else m_q = (m_q + 1) % (MAX + 1);
         end
         2: if (st) m_st = 1;
         default: if (ak) begin m_st = 0; m_q = 0; end
      endcase
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".q"},      int'(q),      m_q);
      check({tag, ".state"},  int'(state),  m_st);
      check({tag, ".busy"},   int'(busy),   int'(m_st == 1 || m_st == 2));
      check({tag, ".paused"}, int'(paused), int'(m_st == 2));
      check({tag, ".tc"},     int'(tc),     int'(m_st == 1 && m_q == m_lim));
      check({tag, ".done"},   int'(done),   int'(m_st == 3));
   endtask

   // Drive one cycle of inputs, advance the clock, then compare against the model.
   task automatic apply(input string tag, input bit rs, input bit st, input bit sp,
                        input bit md, input int lm, input bit ak);
      reset = rs; start = st; stop = sp; mode = md; limit = W'(lm); ack = ak;
      @(posedge clk);
      model_step(rs, st, sp, md, lm, ak);
      #1;
      check_model(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) apply(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = '0; ack = 1'b0;

      // rst st sp md lim ak | q st tc done
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 2'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 7'd0, 2'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd3, 1'b0, 7'd0, 2'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'd9, 1'b0, 7'd1, 2'd1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd2, 2'd1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd3, 2'd1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd3, 2'd3, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 7'd3, 2'd3, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd0, 2'd0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 7'd0, 2'd0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 2'd1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd5, 1'b0, 7'd0, 2'd3, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd0, 2'd0, 1'b0, 1'b0};

      for (int i = 0; i < 13; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].st, vecs[i].sp,
               vecs[i].md, int'(vecs[i].lim), vecs[i].ak);
         check($sformatf("vec%0d.tq", i),    int'(q),     int'(vecs[i].eq));
         check($sformatf("vec%0d.tst", i),   int'(state), int'(vecs[i].est));
         check($sformatf("vec%0d.ttc", i),   int'(tc),    int'(vecs[i].etc));
         check($sformatf("vec%0d.tdone", i), int'(done),  int'(vecs[i].edone));
      end

      // Reset held two cycles, then quiet idle.
      apply("rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply("rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      idle("idle", 10);

      // One-shot to 5, long done hold, ack.
      apply("os_start", 1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b0);
      idle("os_run", 5);
      check("os_tc_at5", int'(tc), 1);
      idle("os_done", 20);
      check("os_hold_q", int'(q), 5);
      apply("os_ack", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      check("os_ack_q", int'(q), 0);

      // Auto-reload at 3 while the limit input moves to 9.
      apply("ar_start", 1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0);
      for (int i = 0; i < 12; i++) begin
         apply("ar_run", 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0);
         check("ar_seq", int'(q), (i + 1) % 4);
      end
      apply("ar_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

      // Pause at 4, collisions in PAUSE and RUN, resume to done.
      apply("pr_start", 1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b0);
      idle("pr_run", 4);
      apply("pr_stop", 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      check("pr_paused", int'(paused), 1);
      idle("pr_hold", 5);
      check("pr_hold_q", int'(q), 4);
      apply("pr_both_p", 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      check("pr_both_p_st", int'(state), 1);
      apply("pr_both_r", 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      check("pr_both_r_st", int'(state), 2);
      check("pr_both_r_q", int'(q), 4);
      apply("pr_resume", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle("pr_run2", 6);
      check("pr_q10", int'(q), 10);
      idle("pr_done", 1);
      check("pr_done", int'(done), 1);
      apply("pr_ack", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

      // Full-range auto-reload wrap.
      apply("max_start", 1'b0, 1'b1, 1'b0, 1'b1, MAX, 1'b0);
      idle("max_run", MAX);
      check("max_q", int'(q), MAX);
      check("max_tc", int'(tc), 1);
      idle("max_wrap", 1);
      check("max_wrap_q", int'(q), 0);

      // Reset mid-count, fresh sampling afterwards, reset in DONE.
      apply("rm_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply("rm_start", 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b0);
      idle("rm_run", 6);
      apply("rm_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("rm_rst_st", int'(state), 0);
      apply("rm_restart", 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0);
      idle("rm_run2", 3);
      check("rm_fresh_q", int'(q), 0);
      check("rm_fresh_st", int'(state), 1);
      apply("rd_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      apply("rd_start", 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
      idle("rd_run", 2);
      check("rd_done", int'(done), 1);
      apply("rd_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      check("rd_rst_done", int'(done), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         automatic bit rs = ($urandom_range(0, 99) == 0);
         automatic bit st = ($urandom_range(0, 3) == 0);
         automatic bit sp = ($urandom_range(0, 7) == 0);
         automatic bit ak = ($urandom_range(0, 3) == 0);
         automatic bit md = 1'($urandom_range(0, 1));
         automatic int lm = ($urandom_range(0, 15) == 0) ? MAX : int'($urandom_range(0, 12));
         apply("rnd", rs, st, sp, md, lm, ak);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
